seg7_scan_driver: RTL

//  Time-multiplexed scan driver directly upstream of the BCD-to-7-segment decoder.
//  - Holds NDIG BCD digits and presents one digit at a time on NUM; NUM feeds the decoder.
//  - Drives active-low digit enables AN in step with NUM.
//  - Inserts a dead-time gap between digits to suppress ghosting.
//  - Double-buffers the digits so that every displayed frame is consistent.

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/seg7_slot_timer.sv | 50 +++++
 rtl/seg7_scan_driver.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types and helpers for the 7-segment scan driver.
// Optional build macro used by seg7_scan_driver: LEADING_ZERO_BLANK_EN.
package seg7_pkg;

    // Decoder blank code: the downstream BCD decoder renders this as dark.
    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Widest digit buffer the helper accepts (NDIG <= 8).
    localparam int unsigned MAX_DIG = 8;

    typedef enum logic {BLANK, DRIVE} scan_state_t;

    // Pick BCD digit idx out of a packed buffer (digit 0 in the low nibble).
    function automatic logic [3:0] digit_sel(input logic [4*MAX_DIG-1:0] dig_buf,
                                             input int unsigned          idx);
        logic [4*MAX_DIG-1:0] shifted;
        shifted = dig_buf >> (4 * idx);
        return shifted[3:0];
    endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Slot prescaler: counts PRESCALE cycles per digit slot and flags the slot start,
// the last dead-time cycle and the last cycle of the slot.
module seg7_slot_timer #(
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned DEAD     = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic slot_start_o,
    output logic dead_done_o,
    output logic slot_end_o
);

    localparam int unsigned     CntW     = $clog2(PRESCALE);
    localparam logic [CntW-1:0] CntLast  = CntW'(PRESCALE - 1);
    localparam logic [CntW-1:0] DeadLast = CntW'((DEAD == 0) ? 0 : DEAD - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Flags decoded from the current count.
    always_comb begin
        slot_start_o = (cnt_q == '0);
        slot_end_o   = (cnt_q == CntLast);
        // With no dead time the drive phase starts on the slot's first cycle.
        dead_done_o  = (DEAD == 0) ? 1'b1 : (cnt_q == DeadLast);
    end

    // Next count: wrap at the slot end, clear while the scan is disabled.
    always_comb begin
        cnt_d = cnt_q;
        if (!en_i) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed, double-buffered scan driver feeding a BCD-to-7-segment decoder.
// Build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 is always shown).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NDIG     = 4,
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned DEAD     = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              load_i,
    input  logic [4*NDIG-1:0] digits_i,
    output logic [3:0]        num_o,
    output logic [NDIG-1:0]   an_o,
    output logic              frame_o
);

    localparam int unsigned     IdxW    = $clog2(NDIG);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NDIG - 1);

    scan_state_t       state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [3:0]        num_q, num_d;
    logic [NDIG-1:0]   an_q, an_d;
    logic              frame_q, frame_d;
    logic [4*NDIG-1:0] pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic [4*NDIG-1:0] active_q, active_d;

    logic                 slot_start;
    logic                 dead_done;
    logic                 slot_end;
    logic                 drive_now;
    logic [4*NDIG-1:0]    act_nxt;
    logic [4*MAX_DIG-1:0] act_ext;

    seg7_slot_timer #(
        .PRESCALE (PRESCALE),
        .DEAD     (DEAD)
    ) u_slot_timer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .en_i         (en_i),
        .slot_start_o (slot_start),
        .dead_done_o  (dead_done),
        .slot_end_o   (slot_end)
    );

    // Scan FSM, buffer swap and next values of the registered outputs.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        num_d      = num_q;
        an_d       = '1;
        frame_d    = 1'b0;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        active_d   = active_q;
        act_nxt    = active_q;
        act_ext    = '0;
        // DEAD = 0 leaves BLANK transient, so the digit is driven from the slot's first cycle.
        drive_now  = (state_q == DRIVE) || (DEAD == 0);

        if (en_i) begin
            unique case (state_q)
                BLANK:   if (dead_done) state_d = DRIVE;
                DRIVE:   state_d = DRIVE;
                default: state_d = BLANK;
            endcase

            if (slot_end) begin
                state_d = BLANK;
                idx_d   = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
            end

            // AN follows the phase of the cycle being left, so it trails NUM by DEAD cycles.
            if (drive_now) begin
                an_d = ~({{(NDIG-1){1'b0}}, 1'b1} << idx_q);
            end

            if (slot_start) begin
                if (idx_q == '0) begin
                    frame_d = 1'b1;
                    if (pend_vld_q) begin
                        act_nxt    = pend_q;
                        pend_vld_d = 1'b0;
                    end
                end
                active_d                = act_nxt;
                act_ext[4*NDIG-1:0]     = act_nxt;
                num_d                   = digit_sel(act_ext, int'(idx_q));
`ifdef LEADING_ZERO_BLANK_EN
                // This digit and every digit above it are zero: render dark.
                if ((idx_q != '0) && ((act_ext >> (4 * idx_q)) == '0)) begin
                    num_d = BLANK_CODE;
                end
`endif
            end
        end else begin
            state_d = BLANK;
            idx_d   = '0;
            num_d   = BLANK_CODE;
        end

        // Applied last so a LOAD on the frame boundary re-arms the pending buffer.
        if (load_i) begin
            pend_d     = digits_i;
            pend_vld_d = 1'b1;
        end
    end

    // State, buffers and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= BLANK;
            idx_q      <= '0;
            num_q      <= BLANK_CODE;
            an_q       <= '1;
            frame_q    <= 1'b0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            active_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            num_q      <= num_d;
            an_q       <= an_d;
            frame_q    <= frame_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            active_q   <= active_d;
        end
    end

    assign num_o   = num_q;
    assign an_o    = an_q;
    assign frame_o = frame_q;

endmodule
